// File: rtl/rf_stream_reader_pkg.sv
// Shared definitions for the register-file stream reader: FSM encoding and default widths.
package rf_stream_reader_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/rs_out_reg.sv
// Output holding stage: captures one register beat and holds it until the sink accepts it.
module rs_out_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              load_last,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
            last  <= 1'b0;
        end else begin
            // flush drops a pending beat outright; a load refills the slot even on a transfer edge
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (load && !flush) begin
                data <= load_data;
                addr <= load_addr;
                last <= load_last;
            end
        end
    end

endmodule

// File: rtl/rf_stream_reader.sv
// Reads a burst of consecutive register-file entries and streams them out with valid/ready.
module rf_stream_reader
    import rf_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic              capture;
    logic              transfer;
    logic              run_abort;
    logic              last_beat;

    assign run_abort = (state == RUN) && abort;
    // an aborting edge never reads the register file
    assign capture   = (state == RUN) && !abort && (!m_valid || m_ready) && (remaining != '0);
    assign transfer  = m_valid && m_ready;
    assign last_beat = (remaining == (ADDR_W+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (count == '0) ? FLUSH : RUN;
            RUN:     if (abort || (transfer && m_last)) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
        end else if ((state == IDLE) && start) begin
            ptr       <= base_addr;
            remaining <= count;
        end else if (run_abort) begin
            remaining <= '0;
        end else if (capture) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    rs_out_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture),
        .flush     (run_abort),
        .ready     (m_ready),
        .load_data (rd_data),
        .load_addr (ptr),
        .load_last (last_beat),
        .valid     (m_valid),
        .data      (m_data),
        .addr      (m_addr),
        .last      (m_last)
    );

    assign rd_addr = ptr;
    assign busy    = (state != IDLE);
    assign done    = (state == FLUSH);

endmodule

// File: tb/tb_rf_stream_reader.sv
// Scoreboard bench for rf_stream_reader against a preloaded 16x32 register file model.
module tb_rf_stream_reader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rf [16];

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t held;
    bit    stalled = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    int    transfers = 0;
    int    done_cnt = 0;
    int    busy_cnt = 0;
    int    ready_mode = 0;
    int    ready_phase = 0;

    rf_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_addr    (m_addr),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'hA000_0000 + i;
    end

    assign rd_data = rf[rd_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Sink ready: 0 = always ready, 1 = random, 2 = pattern 1,0,0 repeating
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: begin
                m_ready = (ready_phase % 3 == 0);
                ready_phase++;
            end
        endcase
    end

    // Monitor: pops the scoreboard on every transfer, checks stability while stalled
    always @(negedge clk) begin
        beat_t e;
        beat_t cur;
        if (rst_n) begin
            cur = {m_addr, m_data, m_last};
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (m_valid && stalled) check("hold_stable", 64'(cur), 64'(held));
            if (m_valid && m_ready) begin
                transfers++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got addr %0d data %0h, required none", m_addr, m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur), 64'(e));
                end
            end
            stalled = m_valid && !m_ready;
            held    = cur;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic push_burst(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            beat_t b;
            b.addr = 4'((base + i) % 16);
            b.data = 32'hA000_0000 + 32'(b.addr);
            b.last = (i == cnt - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_start(input int base, input int cnt);
        base_addr = ADDR_W'(base);
        count     = (ADDR_W+1)'(cnt);
        start     = 1'b1;
        push_burst(base, cnt);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_timeout"}, 64'(busy), 64'(0));
        check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int t0;
        int b0;
        int n;

        // Reset values
        #2;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_busy_done", 64'({busy, done}), 64'(0));

        // Basic burst, started on the first edge after reset release
        ready_mode = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        d0 = done_cnt;
        do_start(2, 4);
        check("basic_busy", 64'(busy), 64'(1));
        check("basic_no_early_valid", 64'(m_valid), 64'(0));
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("basic_valid", 64'(m_valid), 64'(1));
            check("basic_data", 64'(m_data), 64'(32'hA000_0001 + k));
            check("basic_last", 64'(m_last), 64'(k == 4));
        end
        @(posedge clk); #1;
        check("basic_done", 64'({done, m_valid}), 64'(2'b10));
        @(posedge clk); #1;
        check("basic_after_done", 64'({busy, done}), 64'(0));
        check("basic_done_count", 64'(done_cnt - d0), 64'(1));

        // Wrap across address 15 -> 0
        d0 = done_cnt;
        do_start(14, 4);
        wait_idle("wrap");
        check("wrap_done_count", 64'(done_cnt - d0), 64'(1));

        // Backpressure pattern 1,0,0,...
        ready_mode = 2;
        ready_phase = 0;
        t0 = transfers;
        do_start(0, 3);
        wait_idle("bp");
        check("bp_transfers", 64'(transfers - t0), 64'(3));
        ready_mode = 0;

        // Zero count
        d0 = done_cnt; b0 = busy_cnt; t0 = transfers;
        do_start(7, 0);
        wait_idle("zero");
        check("zero_busy_cycles", 64'(busy_cnt - b0), 64'(1));
        check("zero_done_count", 64'(done_cnt - d0), 64'(1));
        check("zero_transfers", 64'(transfers - t0), 64'(0));

        // Abort in IDLE has no effect
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort", 64'({busy, done}), 64'(0));

        // start while busy is ignored
        ready_mode = 1;
        do_start(3, 5);
        @(posedge clk); #1;
        base_addr = 4'd9; count = 5'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("start_ignored");
        ready_mode = 0;

        // Abort after the second transfer
        d0 = done_cnt; t0 = transfers;
        do_start(5, 8);
        n = 0;
        while ((transfers - t0) < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reached_2", 64'(transfers - t0 >= 2), 64'(1));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_valid_low", 64'(m_valid), 64'(0));
        check("abort_done", 64'(done), 64'(1));
        @(posedge clk); #1;
        check("abort_done_once", 64'(done_cnt - d0), 64'(1));
        do_start(1, 2);
        check("abort_restart_busy", 64'(busy), 64'(1));
        wait_idle("abort_restart");

        // Async reset mid-burst
        ready_mode = 2;
        ready_phase = 1;
        do_start(0, 8);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_reset_valid", 64'(m_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_outputs", 64'({m_valid, m_last, m_addr, busy, done, rd_addr}), 64'(0));
        check("areset_data", 64'(m_data), 64'(0));
        exp_q.delete();
        ready_mode = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("no_done_after_reset", 64'(done_cnt - d0), 64'(0));
        check("idle_after_reset", 64'(busy), 64'(0));

        // Randomized bursts with random sink backpressure
        ready_mode = 1;
        for (int it = 0; it < 40; it++) begin
            do_start(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)));
            wait_idle("random");
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
